// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default operand width.
package mips_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: unsigned shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int N     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  md_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     opnd_q, acc_hi_q, acc_lo_q;
  logic [N-1:0]     hi_q, lo_q;
  logic             is_div_q, neg_lo_q, neg_hi_q, div_zero_q;
  logic             busy_q, done_q;

  logic             is_muldiv, is_signed, is_div_op;
  logic             idle, accept, wr_mthi, wr_mtlo;
  logic             rs_neg, rt_neg;
  logic [N-1:0]     rs_mag, rt_mag;
  logic [N:0]       mul_sum, div_shift;
  logic             div_ok;
  logic [N-1:0]     div_rem;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     res_hi, res_lo;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    is_muldiv = 1'b0;
    is_signed = 1'b0;
    is_div_op = 1'b0;
    case (op)
      OP_MULT:  begin is_muldiv = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_muldiv = 1'b1;
      OP_DIV:   begin is_muldiv = 1'b1; is_signed = 1'b1; is_div_op = 1'b1; end
      OP_DIVU:  begin is_muldiv = 1'b1; is_div_op = 1'b1; end
      default:  ;
    endcase
  end

  assign idle    = (state_q == ST_IDLE);
  assign accept  = idle && start && is_muldiv;
  assign wr_mthi = idle && start && (op == OP_MTHI);
  assign wr_mtlo = idle && start && (op == OP_MTLO);

  assign rs_neg = is_signed && rs_val[N-1];
  assign rt_neg = is_signed && rt_val[N-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // One iteration of each algorithm; the FSM picks which one is committed.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[N-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd_q});
  assign div_rem   = div_shift[N-1:0] - opnd_q;

  assign prod = {acc_hi_q, acc_lo_q};

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_div_q) begin
      res_hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
      // A zero divisor leaves |rs| in the remainder, so hi already reads rs_val.
      res_lo = div_zero_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
    end else begin
      {res_hi, res_lo} = neg_lo_q ? -prod : prod;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: if (cnt_q == LAST_ITER) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FIX);
      if (accept)                  busy_q <= 1'b1;
      else if (state_q == ST_FIX)  busy_q <= 1'b0;
    end
  end

  // NOTE: the iteration datapath is reset along with HI/LO; it is a handful of
  // flops, and it keeps an aborted operation from leaving X in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      cnt_q      <= '0;
      opnd_q     <= is_div_op ? rt_mag : rs_mag;
      acc_hi_q   <= '0;
      acc_lo_q   <= is_div_op ? rs_mag : rt_mag;
      is_div_q   <= is_div_op;
      neg_lo_q   <= rs_neg ^ rt_neg;
      neg_hi_q   <= rs_neg;
      div_zero_q <= is_div_op && (rt_val == '0);
    end else if (state_q == ST_CALC) begin
      cnt_q <= cnt_q + 1'b1;
      if (is_div_q) begin
        acc_hi_q <= div_ok ? div_rem : div_shift[N-1:0];
        acc_lo_q <= {acc_lo_q[N-2:0], div_ok};
      end else begin
        acc_hi_q <= mul_sum[N:1];
        acc_lo_q <= {mul_sum[0], acc_lo_q[N-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == ST_FIX) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (wr_mthi) hi_q <= rs_val;
      if (wr_mtlo) lo_q <= rs_val;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: fixed vectors, hand-written timing
// sequences, and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } hilo_t;

  vec_t  vecs[12];
  hilo_t m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the architectural rules, using 64-bit arithmetic.
  function automatic hilo_t model(input logic [2:0] o, input logic [31:0] rs,
                                  input logic [31:0] rt, input hilo_t cur);
    hilo_t  r;
    longint a, b, q, rm;
    logic [63:0] p;
    r = cur;
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(rs)) * longint'($signed(rt)));
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, rs} * {32'b0, rt};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      3'd2: begin
        if (rt == 0) begin
          r.hi = rs; r.lo = '1;
        end else begin
          a = longint'($signed(rs)); b = longint'($signed(rt));
          q = a / b; rm = a % b;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end
      end
      3'd3: begin
        if (rt == 0) begin
          r.hi = rs; r.lo = '1;
        end else begin
          r.lo = rs / rt; r.hi = rs % rt;
        end
      end
      3'd4: r.hi = rs;
      3'd5: r.lo = rs;
      default: ;
    endcase
    return r;
  endfunction

  // Called at a negedge; drives a one-edge start pulse and returns at posedge+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start edge until done is seen; bounded.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no done within 60 cycles (op %0d)", op);
  endtask

  initial begin
    int lat, bcnt;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[6]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{3'd1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed vectors; each new op is issued in the previous op's done cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, 34);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 33);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    m.hi = hi; m.lo = lo;

    // MTHI is single-cycle and never raises busy or done.
    issue(3'd4, 32'h12345678, 32'h0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", busy, 0);
    @(negedge clk);
    check("mthi_busy_later", busy, 0);
    check("mthi_done", done, 0);

    // MULTU with an MTLO start pulsed mid-CALC: the MTLO must be dropped.
    issue(3'd1, 32'd2, 32'd3);
    repeat (10) @(negedge clk);
    issue(3'd5, 32'h0000DEAD, 32'h0);
    check("calc_lo_stable", lo, m.lo);
    check("calc_hi_stable", hi, 32'h12345678);
    wait_done(lat, bcnt);
    check("busy_start_hi", hi, 0);
    check("busy_start_lo", lo, 6);
    @(negedge clk);

    // Asynchronous reset in the middle of a DIVU.
    issue(3'd3, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd1, 32'd5, 32'd5);
    wait_done(lat, bcnt);
    check("after_reset_lo", lo, 25);
    check("after_reset_hi", hi, 0);

    // Back-to-back: second start in the done cycle of the first.
    issue(3'd0, 32'hFFFFFFF6, 32'd4);
    wait_done(lat, bcnt);
    check("b2b_first_lo", lo, 32'hFFFFFFD8);
    issue(3'd2, 32'd100, 32'hFFFFFFF5);
    wait_done(lat, bcnt);
    check("b2b_second_latency", lat, 34);
    check("b2b_second_lo", lo, 32'hFFFFFFF7);
    check("b2b_second_hi", hi, 32'd1);
    @(negedge clk);
    check("b2b_done_one_cycle", done, 0);

    // Randomized ops including MTHI/MTLO and ignored encodings.
    m.hi = hi; m.lo = lo;
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      m = model(ro, ra, rb, m);
      issue(ro, ra, rb);
      if (ro <= 3'd3) begin
        wait_done(lat, bcnt);
        check($sformatf("rand%0d_latency", i), lat, 34);
      end else begin
        check($sformatf("rand%0d_nobusy", i), busy, 0);
        @(negedge clk);
      end
      check($sformatf("rand%0d_hi op%0d", i, ro), hi, m.hi);
      check($sformatf("rand%0d_lo op%0d", i, ro), lo, m.lo);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
